// File: rtl/ray_scheduler_pkg.sv
// rtl/ray_scheduler_pkg.sv - shared scheduler state encoding and pixel coordinate widths
// Purpose: the ray generator and the scheduler import the coordinate widths
//          from here so both sides agree on the same values.
// Ports:   none (package).
package ray_scheduler_pkg;

    localparam int H_BITS = 11;
    localparam int V_BITS = 10;
    localparam int S_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    // Width of a counter that must hold every value from 0 to max.
    function automatic int count_bits(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/ray_scheduler_if.sv
// rtl/ray_scheduler_if.sv - control and ray-issue signal bundle for ray_scheduler
// Purpose: groups the frame control, issue handshake and status signals.
// Ports:   master = scheduler side (drives new_ray, coordinates, status);
//          slave  = environment side (drives start, issue_ready, ray_retired).
interface ray_scheduler_if #(
    parameter int MAX_INFLIGHT = 8
);
    import ray_scheduler_pkg::*;

    localparam int C_BITS = count_bits(MAX_INFLIGHT);

    logic              start;
    logic              issue_ready;
    logic              ray_retired;
    logic              new_ray;
    logic [H_BITS-1:0] pixel_h_out;
    logic [V_BITS-1:0] pixel_v_out;
    logic [S_BITS-1:0] sample_idx;
    logic              busy;
    logic              frame_done;
    logic [C_BITS-1:0] inflight;

    modport master (
        input  start, issue_ready, ray_retired,
        output new_ray, pixel_h_out, pixel_v_out, sample_idx,
        output busy, frame_done, inflight
    );

    modport slave (
        output start, issue_ready, ray_retired,
        input  new_ray, pixel_h_out, pixel_v_out, sample_idx,
        input  busy, frame_done, inflight
    );

endinterface

// File: rtl/ray_scheduler_credit_counter.sv
// rtl/ray_scheduler_credit_counter.sv - bounded in-flight credit counter
// Purpose: counts issued-but-unretired items up to MAX.
// Ports:   clk, rst (sync, active-high); inc = one item issued;
//          dec = one item retired (ignored at zero);
//          count = current usage; has_credit = count below MAX.
module ray_scheduler_credit_counter #(
    parameter  int MAX = 8,
    localparam int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         has_credit
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         dec_ok;

    always_comb begin
        count_d = count_q;
        // A retire with nothing outstanding is a stray pulse, not an underflow.
        dec_ok  = dec && (count_q != '0);
        if (inc && !dec_ok) begin
            count_d = count_q + W'(1);
        end else if (!inc && dec_ok) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Credit is judged on the registered count, so a retire never frees a
    // slot for an issue in the same cycle.
    assign count      = count_q;
    assign has_credit = (count_q < W'(MAX));

endmodule

// File: rtl/ray_scheduler.sv
// rtl/ray_scheduler.sv - frame-level raster walker issuing credit-limited rays
// Purpose: walks a WIDTH x HEIGHT frame in raster order, SAMPLES rays per
//          pixel, one new_ray strobe per ray, bounded by MAX_INFLIGHT credits;
//          frame_done pulses once every issued ray has been retired.
// Ports:   clk, rst (sync, active-high);
//          bus (master): start, issue_ready, ray_retired in;
//          new_ray, pixel_h_out, pixel_v_out, sample_idx, busy,
//          frame_done, inflight out.
module ray_scheduler
    import ray_scheduler_pkg::*;
#(
    parameter int WIDTH        = 1280,
    parameter int HEIGHT       = 720,
    parameter int SAMPLES      = 1,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic            clk,
    input  logic            rst,
    ray_scheduler_if.master bus
);

    localparam int C_BITS = count_bits(MAX_INFLIGHT);

    if (WIDTH < 1 || WIDTH > 2048) begin : g_bad_width
        $error("ray_scheduler: WIDTH must be in 1..2048");
    end
    if (HEIGHT < 1 || HEIGHT > 1024) begin : g_bad_height
        $error("ray_scheduler: HEIGHT must be in 1..1024");
    end
    if (SAMPLES < 1 || SAMPLES > 256) begin : g_bad_samples
        $error("ray_scheduler: SAMPLES must be in 1..256");
    end
    if (MAX_INFLIGHT < 1) begin : g_bad_inflight
        $error("ray_scheduler: MAX_INFLIGHT must be at least 1");
    end

    localparam logic [H_BITS-1:0] LAST_H = H_BITS'(WIDTH - 1);
    localparam logic [V_BITS-1:0] LAST_V = V_BITS'(HEIGHT - 1);
    localparam logic [S_BITS-1:0] LAST_S = S_BITS'(SAMPLES - 1);

    sched_state_t      state_q, state_d;
    logic [H_BITS-1:0] h_q, h_d;
    logic [V_BITS-1:0] v_q, v_d;
    logic [S_BITS-1:0] s_q, s_d;

    logic              fire;
    logic              has_credit;
    logic [C_BITS-1:0] count;
    logic              last_s;
    logic              last_h;
    logic              last_ray;

    assign last_s   = (s_q == LAST_S);
    assign last_h   = (h_q == LAST_H);
    assign last_ray = last_s && last_h && (v_q == LAST_V);

    ray_scheduler_credit_counter #(
        .MAX(MAX_INFLIGHT)
    ) u_credit (
        .clk       (clk),
        .rst       (rst),
        .inc       (fire),
        .dec       (bus.ray_retired),
        .count     (count),
        .has_credit(has_credit)
    );

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        s_d     = s_q;
        fire    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ISSUE;
                    h_d     = '0;
                    v_d     = '0;
                    s_d     = '0;
                end
            end
            ISSUE: begin
                fire = bus.issue_ready && has_credit;
                if (fire) begin
                    // The final ray leaves the coordinates on their last
                    // values instead of wrapping back to the origin.
                    if (last_ray) begin
                        state_d = DRAIN;
                    end else if (!last_s) begin
                        s_d = s_q + S_BITS'(1);
                    end else begin
                        s_d = '0;
                        if (!last_h) begin
                            h_d = h_q + H_BITS'(1);
                        end else begin
                            h_d = '0;
                            v_d = v_q + V_BITS'(1);
                        end
                    end
                end
            end
            DRAIN: begin
                if (count == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // start is not looked at here, so a start coinciding with
                // frame_done is dropped.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            h_q     <= '0;
            v_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            s_q     <= s_d;
        end
    end

    assign bus.new_ray     = fire;
    assign bus.pixel_h_out = h_q;
    assign bus.pixel_v_out = v_q;
    assign bus.sample_idx  = s_q;
    assign bus.busy        = (state_q == ISSUE) || (state_q == DRAIN);
    assign bus.frame_done  = (state_q == DONE);
    assign bus.inflight    = count;

endmodule

// File: tb/tb_ray_scheduler.sv
// tb/tb_ray_scheduler.sv - directed self-checking bench for ray_scheduler
module tb_ray_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Index 0: 4x3, 1 sample, 8 credits. 1: 4x3, 2 samples, 8 credits.
    // 2: 4x3, 1 sample, 2 credits.
    logic        rst_v   [3];
    logic        start_v [3];
    logic        ready_v [3];
    logic        ret_v   [3];
    logic        nr_w    [3];
    logic [10:0] h_w     [3];
    logic [9:0]  v_w     [3];
    logic [7:0]  s_w     [3];
    logic        busy_w  [3];
    logic        done_w  [3];
    logic [3:0]  inf_w   [3];

    int n_checks = 0;
    int n_fail   = 0;

    ray_scheduler_if #(.MAX_INFLIGHT(8)) if_a ();
    ray_scheduler_if #(.MAX_INFLIGHT(8)) if_b ();
    ray_scheduler_if #(.MAX_INFLIGHT(2)) if_c ();

    ray_scheduler #(.WIDTH(4), .HEIGHT(3), .SAMPLES(1), .MAX_INFLIGHT(8))
        dut_a (.clk(clk), .rst(rst_v[0]), .bus(if_a));
    ray_scheduler #(.WIDTH(4), .HEIGHT(3), .SAMPLES(2), .MAX_INFLIGHT(8))
        dut_b (.clk(clk), .rst(rst_v[1]), .bus(if_b));
    ray_scheduler #(.WIDTH(4), .HEIGHT(3), .SAMPLES(1), .MAX_INFLIGHT(2))
        dut_c (.clk(clk), .rst(rst_v[2]), .bus(if_c));

    assign if_a.start = start_v[0];  assign if_a.issue_ready = ready_v[0];  assign if_a.ray_retired = ret_v[0];
    assign if_b.start = start_v[1];  assign if_b.issue_ready = ready_v[1];  assign if_b.ray_retired = ret_v[1];
    assign if_c.start = start_v[2];  assign if_c.issue_ready = ready_v[2];  assign if_c.ray_retired = ret_v[2];

    assign nr_w[0] = if_a.new_ray;   assign nr_w[1] = if_b.new_ray;   assign nr_w[2] = if_c.new_ray;
    assign h_w[0] = if_a.pixel_h_out; assign h_w[1] = if_b.pixel_h_out; assign h_w[2] = if_c.pixel_h_out;
    assign v_w[0] = if_a.pixel_v_out; assign v_w[1] = if_b.pixel_v_out; assign v_w[2] = if_c.pixel_v_out;
    assign s_w[0] = if_a.sample_idx;  assign s_w[1] = if_b.sample_idx;  assign s_w[2] = if_c.sample_idx;
    assign busy_w[0] = if_a.busy;     assign busy_w[1] = if_b.busy;     assign busy_w[2] = if_c.busy;
    assign done_w[0] = if_a.frame_done; assign done_w[1] = if_b.frame_done; assign done_w[2] = if_c.frame_done;
    assign inf_w[0] = 4'(if_a.inflight); assign inf_w[1] = 4'(if_b.inflight); assign inf_w[2] = 4'(if_c.inflight);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs just after the edge, then let outputs settle.
    task automatic tick(input int d, input logic st, input logic rdy, input logic rt);
        @(posedge clk);
        #1;
        start_v[d] = st;
        ready_v[d] = rdy;
        ret_v[d]   = rt;
        #1;
    endtask

    // Full 4x3 frame. Each ray retires 3 cycles after issue. Cycle 0 carries
    // the start pulse; exp_done is the hand-computed frame_done cycle, on which
    // a second start is also driven to confirm it is ignored.
    task automatic run_frame(input int d, input int samples, input bit toggle, input int exp_done);
        int       k;
        int       total;
        int       last_ret;
        int       done_cyc;
        bit [2:0] pend;
        bit       prev_busy;
        logic     rdy;
        k = 0; total = 12 * samples; last_ret = -1; done_cyc = -1; pend = '0; prev_busy = 1'b0;
        for (int cyc = 0; cyc < 200 && done_cyc < 0; cyc++) begin
            rdy = toggle ? logic'(cyc % 2 == 1) : 1'b1;
            tick(d, (cyc == 0) || (cyc == exp_done), rdy, pend[2]);
            if (pend[2]) last_ret = cyc;
            if (cyc == 0) check("start_inflight", inf_w[d], 0);
            if (nr_w[d]) begin
                if (k == 0) check("first_issue_latency", cyc, 1);
                if (k < total) begin
                    check("issue_h", h_w[d], (k / samples) % 4);
                    check("issue_v", v_w[d], (k / samples) / 4);
                    check("issue_s", s_w[d], k % samples);
                end
                k++;
            end else if (busy_w[d] && k < total && cyc > 0) begin
                check("hold_h", h_w[d], (k / samples) % 4);
                check("hold_v", v_w[d], (k / samples) / 4);
                check("hold_s", s_w[d], k % samples);
            end
            if (!toggle && cyc == 6) check("inflight_steady", inf_w[d], 3);
            if (done_w[d]) begin
                done_cyc = cyc;
                check("busy_at_done", busy_w[d], 0);
                check("busy_before_done", prev_busy, 1);
            end
            prev_busy = busy_w[d];
            pend = {pend[1:0], nr_w[d]};
        end
        if (done_cyc < 0) begin
            check("frame_done_timeout", 0, 1);
        end else begin
            check("done_cycle", done_cyc, exp_done);
            check("done_after_retire", done_cyc - last_ret, 2);
        end
        check("ray_count", k, total);
        tick(d, 1'b0, 1'b0, 1'b0);
        check("done_one_cycle", done_w[d], 0);
        check("start_at_done_ignored", busy_w[d], 0);
    endtask

    initial begin : stim
        int n;
        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b1; start_v[i] = 1'b0; ready_v[i] = 1'b0; ret_v[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_new_ray", nr_w[i], 0);
            check("rst_busy", busy_w[i], 0);
            check("rst_done", done_w[i], 0);
            check("rst_inflight", inf_w[i], 0);
        end
        check("rst_h", h_w[0], 0);
        check("rst_v", v_w[0], 0);
        check("rst_s", s_w[0], 0);

        // Plain frame, then two samples per pixel, then gapped issue_ready.
        run_frame(0, 1, 1'b0, 17);
        run_frame(1, 2, 1'b0, 29);
        run_frame(0, 1, 1'b1, 28);

        // Two credits, no retires: issue stalls with inflight pinned at 2.
        n = 0;
        for (int cyc = 0; cyc <= 10; cyc++) begin
            tick(2, logic'(cyc == 0), 1'b1, 1'b0);
            if (nr_w[2]) n++;
        end
        check("credit_limit_issues", n, 2);
        check("credit_limit_inflight", inf_w[2], 2);
        // Retire while full: no issue this cycle, one the next.
        tick(2, 1'b0, 1'b1, 1'b1);
        check("full_retire_no_issue", nr_w[2], 0);
        check("full_retire_inflight", inf_w[2], 2);
        tick(2, 1'b0, 1'b1, 1'b0);
        check("after_retire_issue", nr_w[2], 1);
        check("after_retire_inflight", inf_w[2], 1);
        check("after_retire_h", h_w[2], 2);
        n = 1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            tick(2, 1'b0, 1'b1, 1'b0);
            if (nr_w[2]) n++;
        end
        check("one_more_issue", n, 1);
        check("refilled_inflight", inf_w[2], 2);
        tick(2, 1'b0, 1'b0, 1'b0);
        rst_v[2] = 1'b1;
        tick(2, 1'b0, 1'b0, 1'b0);
        rst_v[2] = 1'b0;

        // Reset after five issues abandons the frame.
        n = 0;
        for (int cyc = 0; cyc <= 5; cyc++) begin
            tick(0, logic'(cyc == 0), 1'b1, 1'b0);
            if (nr_w[0]) n++;
        end
        check("pre_reset_issues", n, 5);
        tick(0, 1'b0, 1'b0, 1'b0);
        check("pre_reset_h", h_w[0], 1);
        check("pre_reset_v", v_w[0], 1);
        check("pre_reset_inflight", inf_w[0], 5);
        rst_v[0] = 1'b1;
        tick(0, 1'b0, 1'b0, 1'b0);
        rst_v[0] = 1'b0;
        check("mid_rst_busy", busy_w[0], 0);
        check("mid_rst_h", h_w[0], 0);
        check("mid_rst_v", v_w[0], 0);
        check("mid_rst_inflight", inf_w[0], 0);
        n = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            tick(0, 1'b0, 1'b1, 1'b1);
            if (done_w[0] || nr_w[0]) n++;
            check("stray_retire_inflight", inf_w[0], 0);
        end
        check("no_done_after_rst", n, 0);
        tick(0, 1'b0, 1'b0, 1'b0);
        check("stray_retire_settled", inf_w[0], 0);
        run_frame(0, 1, 1'b0, 17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
